// File: rtl/tlb_gen_pkg.sv
// tlb_gen_pkg: shared types and helpers for the TLB traffic generator.
//   state_e    : sequencer states (IDLE, ISSUE, WAIT, NEXT, FINISH)
//   mode_e     : address generation mode (MODE_RAND = 0, MODE_STRIDE = 1)
//   lfsr_taps  : Fibonacci feedback tap mask for a given register width
//   lfsr_next  : one shift step of a width-w Fibonacci LFSR (w <= 31)
package tlb_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        NEXT,
        FINISH
    } state_e;

    typedef enum logic {
        MODE_RAND   = 1'b0,
        MODE_STRIDE = 1'b1
    } mode_e;

    // Tap masks for shift-left Fibonacci LFSRs; bit (n-1) set for tap x^n.
    function automatic logic [31:0] lfsr_taps(input int unsigned w);
        case (w)
            4:       lfsr_taps = 32'h0000_000C;
            5:       lfsr_taps = 32'h0000_0014;
            6:       lfsr_taps = 32'h0000_0030;
            7:       lfsr_taps = 32'h0000_0060;
            8:       lfsr_taps = 32'h0000_00B8;
            9:       lfsr_taps = 32'h0000_0110;
            10:      lfsr_taps = 32'h0000_0240;
            11:      lfsr_taps = 32'h0000_0500;
            12:      lfsr_taps = 32'h0000_0829;
            16:      lfsr_taps = 32'h0000_D008;
            default: lfsr_taps = (32'd1 << (w - 1)) | (32'd1 << (w - 2));
        endcase
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] v,
                                              input int unsigned w);
        logic [31:0] mask;
        logic        fb;
        mask      = (32'd1 << w) - 32'd1;
        fb        = ^(v & lfsr_taps(w));
        lfsr_next = ((v << 1) | {31'd0, fb}) & mask;
    endfunction

endpackage

// File: rtl/tlb_gen_lfsr.sv
// tlb_gen_lfsr: Fibonacci LFSR used for random virtual addresses.
//   clk   : clock
//   rst_n : synchronous active-low reset, loads SEED
//   step  : advance one position when high
//   value : current LFSR contents
module tlb_gen_lfsr
    import tlb_gen_pkg::*;
#(
    parameter int unsigned       VA_W = 9,
    parameter logic [VA_W-1:0]   SEED = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [VA_W-1:0]  value
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= SEED;
        end else if (step) begin
            value <= VA_W'(lfsr_next(32'(value), VA_W));
        end
    end

endmodule

// File: rtl/tlb_traffic_gen.sv
// tlb_traffic_gen: issues NUM_REQS translation requests to the speculative
// TLB, with random (LFSR) or strided virtual addresses, and keeps hit,
// speculative-hit and miss statistics of the completions.
//   clk, rst_n          : clock, synchronous active-low reset
//   START, MODE,
//   BASE_ADDR           : run control, MODE/BASE_ADDR sampled at START
//   BUSY, RUN_DONE      : run status, RUN_DONE is a one-cycle pulse
//   TRANS_RQST,
//   SPEC_TLB_RQST,
//   VIRT_ADDR_LOOKUP    : request to the TLB
//   DONE_TRANS, TLB_HIT,
//   SPEC_HIT,
//   PHY_ADDR_TRANS      : TLB response, completion on DONE_TRANS rising edge
//   LAST_VA, LAST_PA    : most recent completed translation
//   REQ_CNT, HIT_CNT,
//   SPEC_HIT_CNT,
//   MISS_CNT            : saturating per-run statistics
//   TIMEOUT_ERR         : sticky WAIT timeout flag
// Optional feature: define TLB_GEN_TIMEOUT_EN to abort a run after
// TIMEOUT_CYC WAIT cycles without completion; otherwise TIMEOUT_ERR is 0.
module tlb_traffic_gen
    import tlb_gen_pkg::*;
#(
    parameter int unsigned       VA_W      = 9,
    parameter int unsigned       PA_W      = 9,
    parameter int unsigned       CNT_W     = 6,
    parameter int unsigned       NUM_REQS  = 4,
    parameter logic [VA_W-1:0]   LFSR_SEED = 9'h1A5,
    parameter int unsigned       STRIDE    = 1
`ifdef TLB_GEN_TIMEOUT_EN
   ,parameter int unsigned       TIMEOUT_CYC = 64
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              START,
    input  logic              MODE,
    input  logic [VA_W-1:0]   BASE_ADDR,
    output logic              BUSY,
    output logic              RUN_DONE,
    output logic              TRANS_RQST,
    output logic              SPEC_TLB_RQST,
    output logic [VA_W-1:0]   VIRT_ADDR_LOOKUP,
    input  logic              DONE_TRANS,
    input  logic              TLB_HIT,
    input  logic              SPEC_HIT,
    input  logic [PA_W-1:0]   PHY_ADDR_TRANS,
    output logic [VA_W-1:0]   LAST_VA,
    output logic [PA_W-1:0]   LAST_PA,
    output logic [CNT_W-1:0]  REQ_CNT,
    output logic [CNT_W-1:0]  HIT_CNT,
    output logic [CNT_W-1:0]  SPEC_HIT_CNT,
    output logic [CNT_W-1:0]  MISS_CNT,
    output logic              TIMEOUT_ERR
);

    // Random addresses keep the MSB clear.
    localparam logic [VA_W-1:0] RAND_MASK = {1'b0, {(VA_W-1){1'b1}}};

    state_e           state;
    mode_e            mode_q;
    logic             done_q;
    logic             comp;
    logic             last_req;
    logic             lfsr_step;
    logic [VA_W-1:0]  lfsr_val;
    logic [VA_W-1:0]  lfsr_nx;

`ifdef TLB_GEN_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]  wait_cnt;
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    assign comp     = DONE_TRANS & ~done_q;
    assign last_req = (REQ_CNT == CNT_W'(NUM_REQS));

    // The NEXT state loads the post-step value directly, so the LFSR is
    // stepped in the same cycle and the address uses its look-ahead.
    assign lfsr_step = (state == NEXT) && (mode_q == MODE_RAND) && !last_req;
    assign lfsr_nx   = VA_W'(lfsr_next(32'(lfsr_val), VA_W));

    tlb_gen_lfsr #(
        .VA_W (VA_W),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (lfsr_step),
        .value (lfsr_val)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            mode_q           <= MODE_RAND;
            done_q           <= 1'b0;
            BUSY             <= 1'b0;
            RUN_DONE         <= 1'b0;
            TRANS_RQST       <= 1'b0;
            SPEC_TLB_RQST    <= 1'b0;
            VIRT_ADDR_LOOKUP <= '0;
            LAST_VA          <= '0;
            LAST_PA          <= '0;
            REQ_CNT          <= '0;
            HIT_CNT          <= '0;
            SPEC_HIT_CNT     <= '0;
            MISS_CNT         <= '0;
`ifdef TLB_GEN_TIMEOUT_EN
            TIMEOUT_ERR      <= 1'b0;
            wait_cnt         <= '0;
`endif
        end else begin
            done_q        <= DONE_TRANS;
            TRANS_RQST    <= 1'b0;
            SPEC_TLB_RQST <= 1'b0;
            RUN_DONE      <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        mode_q       <= mode_e'(MODE);
                        REQ_CNT      <= '0;
                        HIT_CNT      <= '0;
                        SPEC_HIT_CNT <= '0;
                        MISS_CNT     <= '0;
`ifdef TLB_GEN_TIMEOUT_EN
                        TIMEOUT_ERR  <= 1'b0;
`endif
                        VIRT_ADDR_LOOKUP <= (mode_e'(MODE) == MODE_STRIDE)
                                            ? BASE_ADDR : (lfsr_val & RAND_MASK);
                        BUSY          <= 1'b1;
                        TRANS_RQST    <= 1'b1;
                        SPEC_TLB_RQST <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef TLB_GEN_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (comp) begin
                        LAST_VA <= VIRT_ADDR_LOOKUP;
                        LAST_PA <= PHY_ADDR_TRANS;
                        REQ_CNT <= sat_inc(REQ_CNT);
                        if (TLB_HIT) HIT_CNT  <= sat_inc(HIT_CNT);
                        else         MISS_CNT <= sat_inc(MISS_CNT);
                        if (SPEC_HIT) SPEC_HIT_CNT <= sat_inc(SPEC_HIT_CNT);
                        state <= NEXT;
                    end
`ifdef TLB_GEN_TIMEOUT_EN
                    else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        TIMEOUT_ERR <= 1'b1;
                        BUSY        <= 1'b0;
                        RUN_DONE    <= 1'b1;
                        state       <= FINISH;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
`endif
                end
                NEXT: begin
                    if (last_req) begin
                        BUSY     <= 1'b0;
                        RUN_DONE <= 1'b1;
                        state    <= FINISH;
                    end else begin
                        VIRT_ADDR_LOOKUP <= (mode_q == MODE_STRIDE)
                                            ? VIRT_ADDR_LOOKUP + VA_W'(STRIDE)
                                            : (lfsr_nx & RAND_MASK);
                        TRANS_RQST    <= 1'b1;
                        SPEC_TLB_RQST <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_traffic_gen.sv
// tb_tlb_traffic_gen: directed self-checking bench for tlb_traffic_gen.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_tlb_traffic_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        START;
    logic        MODE;
    logic [8:0]  BASE_ADDR;
    logic        BUSY;
    logic        RUN_DONE;
    logic        TRANS_RQST;
    logic        SPEC_TLB_RQST;
    logic [8:0]  VIRT_ADDR_LOOKUP;
    logic        DONE_TRANS;
    logic        TLB_HIT;
    logic        SPEC_HIT;
    logic [8:0]  PHY_ADDR_TRANS;
    logic [8:0]  LAST_VA;
    logic [8:0]  LAST_PA;
    logic [5:0]  REQ_CNT;
    logic [5:0]  HIT_CNT;
    logic [5:0]  SPEC_HIT_CNT;
    logic [5:0]  MISS_CNT;
    logic        TIMEOUT_ERR;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tlb_traffic_gen dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .START            (START),
        .MODE             (MODE),
        .BASE_ADDR        (BASE_ADDR),
        .BUSY             (BUSY),
        .RUN_DONE         (RUN_DONE),
        .TRANS_RQST       (TRANS_RQST),
        .SPEC_TLB_RQST    (SPEC_TLB_RQST),
        .VIRT_ADDR_LOOKUP (VIRT_ADDR_LOOKUP),
        .DONE_TRANS       (DONE_TRANS),
        .TLB_HIT          (TLB_HIT),
        .SPEC_HIT         (SPEC_HIT),
        .PHY_ADDR_TRANS   (PHY_ADDR_TRANS),
        .LAST_VA          (LAST_VA),
        .LAST_PA          (LAST_PA),
        .REQ_CNT          (REQ_CNT),
        .HIT_CNT          (HIT_CNT),
        .SPEC_HIT_CNT     (SPEC_HIT_CNT),
        .MISS_CNT         (MISS_CNT),
        .TIMEOUT_ERR      (TIMEOUT_ERR)
    );

    // Pulse START for one cycle; returns on the falling edge in ISSUE.
    task automatic start_run(input logic mode, input logic [8:0] base);
        @(negedge clk);
        MODE      = mode;
        BASE_ADDR = base;
        START     = 1'b1;
        @(negedge clk);
        START     = 1'b0;
    endtask

    // TLB responder: waits (bounded) for a request, answers `delay` cycles
    // later with a one-cycle DONE_TRANS pulse (or leaves it high).
    task automatic serve(input logic hit, input logic spec, input logic [8:0] pa,
                         input int delay, input bit keep_high,
                         output logic [8:0] va, output logic spec_rq,
                         output bit ok);
        ok      = 1'b0;
        va      = '0;
        spec_rq = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (TRANS_RQST === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) begin
            va      = VIRT_ADDR_LOOKUP;
            spec_rq = SPEC_TLB_RQST;
            repeat (delay) @(negedge clk);
            DONE_TRANS     = 1'b1;
            TLB_HIT        = hit;
            SPEC_HIT       = spec;
            PHY_ADDR_TRANS = pa;
            @(negedge clk);
            if (!keep_high) DONE_TRANS = 1'b0;
        end
    endtask

    // Bounded wait for RUN_DONE; reports elapsed falling edges.
    task automatic wait_run_done(input int limit, output bit ok, output int cycles);
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            if (RUN_DONE === 1'b1) ok = 1'b1;
            else begin
                @(negedge clk);
                cycles++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        START = 1'b1;
        MODE  = 1'b1;
        BASE_ADDR = 9'h0AA;
        DONE_TRANS = 1'b0;
        TLB_HIT = 1'b0;
        SPEC_HIT = 1'b0;
        PHY_ADDR_TRANS = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({BUSY, RUN_DONE, TRANS_RQST, SPEC_TLB_RQST, TIMEOUT_ERR} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {BUSY, RUN_DONE, TRANS_RQST, SPEC_TLB_RQST, TIMEOUT_ERR});
        end
        vectors++;
        if ({VIRT_ADDR_LOOKUP, LAST_VA, LAST_PA} !== 27'h0) begin
            miscompares++;
            $display("FAIL reset_addr: got %h expected 0",
                     {VIRT_ADDR_LOOKUP, LAST_VA, LAST_PA});
        end
        vectors++;
        if ({REQ_CNT, HIT_CNT, SPEC_HIT_CNT, MISS_CNT} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %h expected 0",
                     {REQ_CNT, HIT_CNT, SPEC_HIT_CNT, MISS_CNT});
        end
        START = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({BUSY, TRANS_RQST} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_start_ignored: got %b expected 00", {BUSY, TRANS_RQST});
        end
    endtask

    task automatic test_stride();
        logic [8:0] exp_va [4];
        logic [8:0] va;
        logic       srq;
        bit         ok;
        int         cyc;
        exp_va = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
        start_run(1'b1, 9'h1FE);
        vectors++;
        if (BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL stride_busy: got %b expected 1", BUSY);
        end
        for (int k = 0; k < 4; k++) begin
            serve(1'b1, 1'b0, 9'h100 + 9'(k), 2, 1'b0, va, srq, ok);
            vectors++;
            if (ok !== 1'b1) begin
                miscompares++;
                $display("FAIL stride_req%0d_timeout: got no request expected request", k);
            end
            vectors++;
            if (va !== exp_va[k] || srq !== 1'b1) begin
                miscompares++;
                $display("FAIL stride_va%0d: got %h/%b expected %h/1", k, va, srq, exp_va[k]);
            end
            vectors++;
            if (REQ_CNT !== 6'(k + 1)) begin
                miscompares++;
                $display("FAIL stride_reqcnt%0d: got %0d expected %0d", k, REQ_CNT, k + 1);
            end
            vectors++;
            if (LAST_VA !== exp_va[k] || LAST_PA !== 9'h100 + 9'(k)) begin
                miscompares++;
                $display("FAIL stride_last%0d: got %h/%h expected %h/%h",
                         k, LAST_VA, LAST_PA, exp_va[k], 9'h100 + 9'(k));
            end
        end
        wait_run_done(20, ok, cyc);
        vectors++;
        if (ok !== 1'b1 || BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL stride_run_done: got done=%b busy=%b expected done=1 busy=0", ok, BUSY);
        end
        @(negedge clk);
        vectors++;
        if (RUN_DONE !== 1'b0) begin
            miscompares++;
            $display("FAIL stride_run_done_width: got %b expected 0", RUN_DONE);
        end
        vectors++;
        if ({REQ_CNT, HIT_CNT, SPEC_HIT_CNT, MISS_CNT} !== {6'd4, 6'd4, 6'd0, 6'd0}) begin
            miscompares++;
            $display("FAIL stride_stats: got %0d/%0d/%0d/%0d expected 4/4/0/0",
                     REQ_CNT, HIT_CNT, SPEC_HIT_CNT, MISS_CNT);
        end
    endtask

    task automatic test_random();
        // Seed 1A5, taps x^9+x^5: 1A5 -> 14B -> 097 -> 12F, MSB cleared.
        logic [8:0] exp_va [4];
        logic [8:0] va;
        logic       srq;
        bit         ok;
        int         cyc;
        exp_va = '{9'h0A5, 9'h04B, 9'h097, 9'h02F};
        start_run(1'b0, 9'h155);
        for (int k = 0; k < 4; k++) begin
            serve((k % 2) == 0, 1'b1, 9'h0C0 + 9'(k), 1, 1'b0, va, srq, ok);
            vectors++;
            if (ok !== 1'b1 || va !== exp_va[k]) begin
                miscompares++;
                $display("FAIL random_va%0d: got %h (req=%b) expected %h", k, va, ok, exp_va[k]);
            end
        end
        wait_run_done(20, ok, cyc);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL random_run_done: got 0 expected 1");
        end
        vectors++;
        if ({REQ_CNT, HIT_CNT, SPEC_HIT_CNT, MISS_CNT} !== {6'd4, 6'd2, 6'd4, 6'd2}) begin
            miscompares++;
            $display("FAIL random_stats: got %0d/%0d/%0d/%0d expected 4/2/4/2",
                     REQ_CNT, HIT_CNT, SPEC_HIT_CNT, MISS_CNT);
        end
        vectors++;
        if (LAST_VA !== 9'h02F || LAST_PA !== 9'h0C3) begin
            miscompares++;
            $display("FAIL random_last: got %h/%h expected 02f/0c3", LAST_VA, LAST_PA);
        end
    endtask

    task automatic test_done_held();
        logic [8:0] va;
        logic       srq;
        bit         ok;
        int         cyc;
        start_run(1'b1, 9'h010);
        serve(1'b0, 1'b0, 9'h050, 1, 1'b1, va, srq, ok);
        vectors++;
        if (ok !== 1'b1 || va !== 9'h010 || REQ_CNT !== 6'd1) begin
            miscompares++;
            $display("FAIL held_req0: got va=%h cnt=%0d expected va=010 cnt=1", va, REQ_CNT);
        end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (TRANS_RQST === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        vectors++;
        if (ok !== 1'b1 || VIRT_ADDR_LOOKUP !== 9'h011) begin
            miscompares++;
            $display("FAIL held_req1_issue: got req=%b va=%h expected req=1 va=011",
                     ok, VIRT_ADDR_LOOKUP);
        end
        // START while busy must not restart the run.
        START = 1'b1;
        MODE  = 1'b0;
        BASE_ADDR = 9'h000;
        @(negedge clk);
        START = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (REQ_CNT !== 6'd1 || BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL held_no_double: got cnt=%0d busy=%b expected cnt=1 busy=1",
                     REQ_CNT, BUSY);
        end
        DONE_TRANS = 1'b0;
        @(negedge clk);
        DONE_TRANS = 1'b1;
        PHY_ADDR_TRANS = 9'h051;
        @(negedge clk);
        DONE_TRANS = 1'b0;
        vectors++;
        if (REQ_CNT !== 6'd2 || LAST_VA !== 9'h011 || LAST_PA !== 9'h051) begin
            miscompares++;
            $display("FAIL held_req1_done: got cnt=%0d va=%h pa=%h expected 2/011/051",
                     REQ_CNT, LAST_VA, LAST_PA);
        end
        for (int k = 2; k < 4; k++) begin
            serve(1'b0, 1'b0, 9'h050 + 9'(k), 3, 1'b0, va, srq, ok);
            vectors++;
            if (ok !== 1'b1 || va !== 9'h010 + 9'(k)) begin
                miscompares++;
                $display("FAIL held_va%0d: got %h expected %h", k, va, 9'h010 + 9'(k));
            end
        end
        wait_run_done(20, ok, cyc);
        vectors++;
        if (ok !== 1'b1 || {REQ_CNT, MISS_CNT, HIT_CNT} !== {6'd4, 6'd4, 6'd0}) begin
            miscompares++;
            $display("FAIL held_final: got done=%b cnt=%0d miss=%0d hit=%0d expected 1/4/4/0",
                     ok, REQ_CNT, MISS_CNT, HIT_CNT);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [8:0] va;
        logic       srq;
        bit         ok;
        int         cyc;
        start_run(1'b1, 9'h0F0);
        serve(1'b1, 1'b1, 9'h077, 2, 1'b0, va, srq, ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (TRANS_RQST === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        rst_n = 1'b0;
        DONE_TRANS = 1'b1;
        PHY_ADDR_TRANS = 9'h1EE;
        @(negedge clk);
        vectors++;
        if ({BUSY, RUN_DONE, TRANS_RQST, SPEC_TLB_RQST, VIRT_ADDR_LOOKUP, LAST_VA, LAST_PA}
            !== 31'h0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h expected 0",
                     {BUSY, RUN_DONE, TRANS_RQST, SPEC_TLB_RQST, VIRT_ADDR_LOOKUP, LAST_VA, LAST_PA});
        end
        vectors++;
        if ({REQ_CNT, HIT_CNT, SPEC_HIT_CNT, MISS_CNT} !== 24'h0) begin
            miscompares++;
            $display("FAIL midreset_cnt: got %h expected 0",
                     {REQ_CNT, HIT_CNT, SPEC_HIT_CNT, MISS_CNT});
        end
        rst_n = 1'b1;
        DONE_TRANS = 1'b0;
        @(negedge clk);
        vectors++;
        if (BUSY !== 1'b0 || REQ_CNT !== 6'd0) begin
            miscompares++;
            $display("FAIL midreset_idle: got busy=%b cnt=%0d expected 0/0", BUSY, REQ_CNT);
        end
        start_run(1'b1, 9'h0F0);
        vectors++;
        if (REQ_CNT !== 6'd0 || VIRT_ADDR_LOOKUP !== 9'h0F0) begin
            miscompares++;
            $display("FAIL midreset_restart: got cnt=%0d va=%h expected 0/0f0",
                     REQ_CNT, VIRT_ADDR_LOOKUP);
        end
        for (int k = 0; k < 4; k++) serve(1'b1, 1'b1, 9'h020, 2, 1'b0, va, srq, ok);
        wait_run_done(20, ok, cyc);
        vectors++;
        if (ok !== 1'b1 || {REQ_CNT, HIT_CNT, SPEC_HIT_CNT} !== {6'd4, 6'd4, 6'd4}) begin
            miscompares++;
            $display("FAIL midreset_rerun: got done=%b cnt=%0d hit=%0d spec=%0d expected 1/4/4/4",
                     ok, REQ_CNT, HIT_CNT, SPEC_HIT_CNT);
        end
    endtask

`ifdef TLB_GEN_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int cyc;
        start_run(1'b1, 9'h033);
        // ISSUE cycle, 64 WAIT cycles, then FINISH.
        wait_run_done(200, ok, cyc);
        vectors++;
        if (ok !== 1'b1 || cyc !== 65) begin
            miscompares++;
            $display("FAIL timeout_latency: got done=%b after %0d expected done=1 after 65", ok, cyc);
        end
        vectors++;
        if (TIMEOUT_ERR !== 1'b1 || REQ_CNT !== 6'd0 || BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_flags: got err=%b cnt=%0d busy=%b expected 1/0/0",
                     TIMEOUT_ERR, REQ_CNT, BUSY);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stride();
        test_random();
        test_done_held();
        test_reset_mid_run();
`ifdef TLB_GEN_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
